// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives a WIDTH-bit ALU from a valid/ready command stream,
// holds operands for SETTLE_CYCLES, samples S and returns it on a valid/ready
// response stream. One command in flight at a time.
// Optional build macro ALU_SEQ_CHAIN_EN adds cmd_chain, which feeds the previous
// result back into operand A.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a command; cmd_ready high
// SETTLE | ALU inputs held, settle counter running down to 1
// RESP   | result captured, rsp_valid high until consumer takes it
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int WIDTH         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic             cmd_chain,
`endif
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_l,
  output logic             alu_m,
  output logic             alu_n,
  input  logic [WIDTH-1:0] alu_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_op,
  output logic             busy
);

  // The counter is 4 bits, so the settle window must fit in 1..15.
  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gBadSettle
      $error("alu_op_sequencer: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] CntLoad = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } seqState_t;

  seqState_t  state;
  seqState_t  stateNext;
  logic [3:0] settleCnt;
  logic       cmdAccept;
  logic       settleDone;
  logic [WIDTH-1:0] operandA;

`ifdef ALU_SEQ_CHAIN_EN
  logic [WIDTH-1:0] lastResult;
  assign operandA = cmd_chain ? lastResult : cmd_a;
`else
  assign operandA = cmd_a;
`endif

  assign cmdAccept  = cmd_valid && cmd_ready;
  // Leave SETTLE at count 1 so the counter never reaches 0 while settling.
  assign settleDone = (settleCnt == 4'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state decode.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (cmdAccept) stateNext = SETTLE;
      SETTLE:  if (settleDone) stateNext = RESP;
      RESP:    if (rsp_valid && rsp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only (no path from rsp_ready).
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // Datapath: operand capture, settle timer, result capture and release.
  always_ff @(posedge clk) begin
    if (reset) begin
      settleCnt <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_l     <= 1'b0;
      alu_m     <= 1'b0;
      alu_n     <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
      rsp_valid <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
      lastResult <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (cmdAccept) begin
            alu_a     <= operandA;
            alu_b     <= cmd_b;
            alu_l     <= cmd_op[2];
            alu_m     <= cmd_op[1];
            alu_n     <= cmd_op[0];
            rsp_op    <= cmd_op;
            settleCnt <= CntLoad;
          end
        end
        SETTLE: begin
          if (settleDone) begin
            settleCnt <= '0;
            rsp_data  <= alu_s;
            rsp_valid <= 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
            lastResult <= alu_s;
`endif
          end else begin
            settleCnt <= settleCnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
